// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake, timeout and illegal-opcode report.
// Optional macro IMM_ALU_EN adds addi support (ADDIEX/ADDIWB states).
module multicycle_control_unit #(
   parameter int         WAIT_LIMIT = 16,
   parameter logic [5:0] OP_RTYPE   = 6'd0,
   parameter logic [5:0] OP_LW      = 6'd35,
   parameter logic [5:0] OP_SW      = 6'd43,
   parameter logic [5:0] OP_BEQ     = 6'd4,
   parameter logic [5:0] OP_J       = 6'd2,
   parameter logic [5:0] OP_ADDI    = 6'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_dbg
);

   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BEQ    = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef IMM_ALU_EN
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
`endif

   logic [3:0]    state;
   logic [3:0]    next_state;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_next;
   logic          wait_state;
   logic          timeout;

   // Handshake states and timeout detection; a limit of zero disables the timeout.
   always_comb begin
      wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
      if (WAIT_LIMIT != 0) begin
         timeout = wait_state && !mem_ready && (wait_cnt == CW'(WAIT_LIMIT));
      end else begin
         timeout = 1'b0;
      end
   end

   // Output decode and next-state selection.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      next_state  = state;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (mem_ready) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               next_state = S_DECODE;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:     next_state = S_EXEC;
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_BEQ:       next_state = S_BEQ;
               OP_J:         next_state = S_JUMP;
`ifdef IMM_ALU_EN
               OP_ADDI:      next_state = S_ADDIEX;
`else
               OP_ADDI: begin
                  illegal_op = 1'b1;
                  next_state = S_FETCH;
               end
`endif
               default: begin
                  illegal_op = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (opcode == OP_LW) begin
               next_state = S_MEMRD;
            end else begin
               next_state = S_MEMWR;
            end
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               next_state = S_MEMWB;
            end else if (timeout) begin
               next_state = S_FETCH;
            end else begin
               next_state = S_MEMRD;
            end
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            // Write request is withdrawn in the abandoning cycle.
            MemWrite = !timeout;
            IorD     = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               next_state = S_FETCH;
            end else if (timeout) begin
               next_state = S_FETCH;
            end else begin
               next_state = S_MEMWR;
            end
         end
         S_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 2'b10;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            instr_done  = 1'b1;
            next_state  = S_FETCH;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
`ifdef IMM_ALU_EN
         S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
`endif
         default: next_state = S_FETCH;
      endcase
   end

   // Counter runs only while stalled in a handshake state; any move or success clears it.
   always_comb begin
      if (wait_state && !mem_ready && !timeout && (next_state == state)) begin
         wait_cnt_next = wait_cnt + CW'(1);
      end else begin
         wait_cnt_next = {CW{1'b0}};
      end
   end

   // State and wait-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= {CW{1'b0}};
      end else begin
         state    <= next_state;
         wait_cnt <= wait_cnt_next;
      end
   end

   assign mem_timeout = timeout;
   assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-path model with per-cycle compare plus directed literal checks.
module tb_multicycle_control_unit;

   localparam int WL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic       instr_done, illegal_op, mem_timeout;
   logic [3:0] state_dbg;

   int n_pass = 0;
   int n_chk  = 0;

   int m_st = 0;
   int m_w  = 0;
   int path[$];

   always #5 clk = ~clk;

   multicycle_control_unit #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
      .mem_timeout(mem_timeout), .state_dbg(state_dbg)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   function automatic bit is_wait(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   function automatic bit timed_out(input int s, input bit mr, input int w);
      return is_wait(s) && !mr && (WL != 0) && (w == WL);
   endfunction

   // Expected outputs from the per-state rules, packed in the same order as the DUT vector.
   function automatic logic [22:0] exp_out(input int s, input bit mr, input int w, input logic [5:0] op);
      bit pcw = 0, pcc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
      bit [1:0] asb = 0, aop = 0, pcs = 0;
      bit done = 0, ill = 0, to;
      to = timed_out(s, mr, w);
      case (s)
         0: begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
         1: begin
            asb = 2'd3;
            ill = !(op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2
`ifdef IMM_ALU_EN
                    || op == 6'd8
`endif
                   );
         end
         2: begin asa = 1; asb = 2'd2; end
         3: begin mrd = 1; iod = 1; end
         4: begin m2r = 1; rw = 1; done = 1; end
         5: begin mwr = !to; iod = 1; done = mr; end
         6: begin asa = 1; aop = 2'd2; end
         7: begin rdst = 1; rw = 1; done = 1; end
         8: begin asa = 1; aop = 2'd1; pcc = 1; pcs = 2'd1; done = 1; end
         9: begin pcw = 1; pcs = 2'd2; done = 1; end
         10: begin asa = 1; asb = 2'd2; end
         11: begin rw = 1; done = 1; end
         default: ;
      endcase
      return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill, to, 4'(s)};
   endfunction

   // Per-cycle compare against the model, then advance the model to the state after the next edge.
   always @(negedge clk) begin
      logic [22:0] got, exp;
      int ns;
      bit to;
      got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, mem_timeout, state_dbg};
      exp = exp_out(m_st, mem_ready, m_w, opcode);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL model_cycle: got %h expected %h (model state %0d) at %0t", got, exp, m_st, $time);
      if (rst) begin
         m_st = 0; m_w = 0; path.delete();
      end else begin
         to = timed_out(m_st, mem_ready, m_w);
         ns = m_st;
         if (is_wait(m_st)) begin
            if (mem_ready) begin
               if (m_st == 0) ns = 1;
               else if (path.size() > 0) ns = path.pop_front();
               else ns = 0;
            end else if (to) begin
               ns = 0; path.delete();
            end
         end else if (m_st == 1) begin
            path.delete();
            case (opcode)
               6'd0:  begin path.push_back(6); path.push_back(7); end
               6'd35: begin path.push_back(2); path.push_back(3); path.push_back(4); end
               6'd43: begin path.push_back(2); path.push_back(5); end
               6'd4:  path.push_back(8);
               6'd2:  path.push_back(9);
`ifdef IMM_ALU_EN
               6'd8:  begin path.push_back(10); path.push_back(11); end
`endif
               default: ;
            endcase
            ns = (path.size() > 0) ? path.pop_front() : 0;
         end else begin
            ns = (path.size() > 0) ? path.pop_front() : 0;
         end
         m_w = (!to && ns == m_st && is_wait(m_st)) ? m_w + 1 : 0;
         m_st = ns;
      end
   end

   task automatic cyc(input logic r, input logic [5:0] o, input logic m);
      @(posedge clk); #1;
      rst = r; opcode = o; mem_ready = m;
      @(negedge clk); #1;
   endtask

   initial begin
      int stall;
      logic [5:0] ops [8];
      rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      cyc(0, 6'd0, 0);
      chk("reset_state", state_dbg, 0); chk("reset_memread", MemRead, 1);
      chk("reset_alusrcb", ALUSrcB, 1); chk("reset_regwrite", RegWrite, 0);

      cyc(0, 6'd0, 1); chk("r_fetch", state_dbg, 0); chk("r_irwrite", IRWrite, 1);
      cyc(0, 6'd0, 1); chk("r_decode", state_dbg, 1);
      cyc(0, 6'd0, 1); chk("r_exec", state_dbg, 6); chk("r_exec_aluop", ALUOp, 2);
      cyc(0, 6'd0, 1); chk("r_aluwb", state_dbg, 7); chk("r_regwrite", RegWrite, 1);
      chk("r_regdst", RegDst, 1); chk("r_done", instr_done, 1);
      cyc(0, 6'd0, 1); chk("r_back", state_dbg, 0); chk("r_done_off", instr_done, 0);

      cyc(0, 6'd0, 1); chk("rx_decode", state_dbg, 1);
      cyc(1, 6'd0, 1); chk("rx_exec", state_dbg, 6);
      cyc(1, 6'd0, 1); chk("rx_reset1", state_dbg, 0);
      cyc(0, 6'd0, 0); chk("rx_reset2", state_dbg, 0); chk("rx_memread", MemRead, 1);
      chk("rx_regwrite", RegWrite, 0);

      cyc(0, 6'd35, 1); chk("lw_fetch", state_dbg, 0);
      cyc(0, 6'd35, 1); chk("lw_decode", state_dbg, 1);
      cyc(0, 6'd35, 1); chk("lw_memadr", state_dbg, 2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 6'd35, 0); chk("lw_memrd_wait", state_dbg, 3); chk("lw_iord", IorD, 1);
      end
      cyc(0, 6'd35, 1); chk("lw_memrd_ready", state_dbg, 3);
      cyc(0, 6'd35, 1); chk("lw_memwb", state_dbg, 4); chk("lw_memtoreg", MemtoReg, 1);
      chk("lw_regwrite", RegWrite, 1);

      cyc(0, 6'd63, 1); chk("ill_fetch", state_dbg, 0);
      cyc(0, 6'd63, 1); chk("ill_decode", state_dbg, 1); chk("ill_pulse", illegal_op, 1);
      chk("ill_regwrite", RegWrite, 0); chk("ill_memwrite", MemWrite, 0); chk("ill_pcwrite", PCWrite, 0);
      cyc(0, 6'd63, 0); chk("ill_back", state_dbg, 0); chk("ill_pulse_off", illegal_op, 0);

      for (int i = 0; i < 3; i++) begin
         cyc(0, 6'd0, 0); chk("to_waiting", mem_timeout, 0);
      end
      cyc(0, 6'd0, 0); chk("to_pulse", mem_timeout, 1); chk("to_irwrite", IRWrite, 0);
      chk("to_pcwrite", PCWrite, 0);
      cyc(0, 6'd0, 0); chk("to_restart", state_dbg, 0); chk("to_pulse_off", mem_timeout, 0);

      cyc(0, 6'd2, 1); chk("j_fetch", state_dbg, 0);
      cyc(0, 6'd2, 1); chk("j_decode", state_dbg, 1);
      cyc(0, 6'd2, 1); chk("j_jump", state_dbg, 9); chk("j_pcwrite", PCWrite, 1); chk("j_pcsource", PCSource, 2);
`ifdef IMM_ALU_EN
      cyc(0, 6'd8, 1); chk("addi_fetch", state_dbg, 0);
      cyc(0, 6'd8, 1); chk("addi_decode", state_dbg, 1);
      cyc(0, 6'd8, 1); chk("addi_ex", state_dbg, 10);
      cyc(0, 6'd8, 1); chk("addi_wb", state_dbg, 11); chk("addi_regwrite", RegWrite, 1);
`endif

      ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4;
      ops[4] = 6'd2; ops[5] = 6'd8;  ops[6] = 6'd63; ops[7] = 6'd0;
      stall = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 99) == 0);
         if (stall > 0) begin
            mem_ready = 1'b0; stall--;
         end else begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) stall = $urandom_range(3, 7);
         end
         if (m_st == 0) begin
            int k;
            k = $urandom_range(0, 7);
            opcode = (k == 7) ? 6'($urandom_range(0, 63)) : ops[k];
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
